// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding ROM requester feeding a
// two-entry instruction buffer, with branch redirect and stale-data discard.
//
//  state     | meaning
//  ----------+--------------------------------------------------------
//  S_FETCH   | request outstanding at fetch_pc
//  S_FULL    | buffer holds two entries, no request issued
//  S_DISCARD | request issued before a redirect still in flight; its data is dropped
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_ack_i,
    input  logic [31:0] rom_data_i,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_FULL    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;
    logic [31:0] stale_addr_q;
    logic [31:0] target_aligned;
    logic        req_seen_q;
    logic        ack_ok;
    logic        push;
    logic        pop;
    logic        flush;
    logic        room;
    logic        enter_discard;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic [31:0] head_pc_q;
    logic [31:0] head_inst_q;
    logic [31:0] tail_pc_q;
    logic [31:0] tail_inst_q;

    // Low address bits are masked off so every redirect lands word aligned.
    assign target_aligned = branch_target_i & 32'hFFFF_FFFC;

    assign if_valid = (count_q != 2'd0);
    assign if_pc    = if_valid ? head_pc_q   : 32'h0000_0000;
    assign if_inst  = if_valid ? head_inst_q : 32'h0000_0000;

    // A redirect squashes the dequeue; popping an empty buffer cannot happen.
    assign pop  = if_valid & ~stall_i & ~branch_flag_i;
    assign room = (count_q != 2'd2) | pop;

    // Request is forced low while reset is held so it drops asynchronously.
    assign rom_req_o  = ~rst & (state_q != S_FULL);
    assign rom_addr_o = (state_q == S_DISCARD) ? stale_addr_q : fetch_pc_q;

    // An ack only counts if the request was visible on the previous cycle;
    // this rejects a response to a request that reset abandoned.
    assign ack_ok = rom_ack_i & req_seen_q & (state_q != S_FULL);

    // Next-state, fetch pointer advance and buffer push/flush decisions.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        push          = 1'b0;
        flush         = 1'b0;
        enter_discard = 1'b0;
        count_d       = count_q;
        if (branch_flag_i) begin
            flush      = 1'b1;
            count_d    = 2'd0;
            fetch_pc_d = target_aligned;
            case (state_q)
                S_FETCH: begin
                    if (ack_ok) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d       = S_DISCARD;
                        enter_discard = 1'b1;
                    end
                end
                S_DISCARD: state_d = ack_ok ? S_FETCH : S_DISCARD;
                default:   state_d = S_FETCH;
            endcase
        end else begin
            if ((state_q == S_FETCH) && ack_ok && room) begin
                push       = 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            case (state_q)
                S_FETCH:   state_d = (count_d == 2'd2) ? S_FULL : S_FETCH;
                S_FULL:    state_d = pop ? S_FETCH : S_FULL;
                S_DISCARD: state_d = ack_ok ? S_FETCH : S_DISCARD;
                default:   state_d = S_FETCH;
            endcase
        end
    end

    // State register, fetch pointer and the address held during discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            fetch_pc_q   <= RESET_PC;
            stale_addr_q <= 32'h0000_0000;
            req_seen_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_seen_q <= rom_req_o;
            if (enter_discard) begin
                stale_addr_q <= fetch_pc_q;
            end
        end
    end

    // Two-entry buffer: head is presented, tail backs it up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= 2'd0;
            head_pc_q   <= 32'h0000_0000;
            head_inst_q <= 32'h0000_0000;
            tail_pc_q   <= 32'h0000_0000;
            tail_inst_q <= 32'h0000_0000;
        end else begin
            count_q <= count_d;
            if (!flush) begin
                if (push && ((count_q == 2'd0) || (pop && (count_q == 2'd1)))) begin
                    head_pc_q   <= fetch_pc_q;
                    head_inst_q <= rom_data_i;
                end else if (pop) begin
                    head_pc_q   <= tail_pc_q;
                    head_inst_q <= tail_inst_q;
                end
                if (push && (((count_q == 2'd1) && !pop) || ((count_q == 2'd2) && pop))) begin
                    tail_pc_q   <= fetch_pc_q;
                    tail_inst_q <= rom_data_i;
                end
            end
        end
    end

endmodule
